// File: rtl/mult_share_pkg.sv
// Shared definitions for the multiplier-sharing arbiter.
// Contents:
//   NREQ_MAX, PROD_W, OP_W  - width/size limits of the block
//   IDX_W                   - width of a requester index at NREQ_MAX
//   rr_pick(valid, ptr, n)  - round-robin pick: first set bit of valid
//                             scanning ptr, ptr+1, ... modulo n
package mult_share_pkg;

    localparam int NREQ_MAX = 8;
    localparam int PROD_W   = 16;
    localparam int OP_W     = 8;
    localparam int IDX_W    = 3;

    // Scan starts at ptr and wraps at nreq. ptr < nreq and k < nreq, so the
    // raw sum is below 2*nreq and a single conditional subtract performs the wrap.
    // The result is only meaningful when valid has at least one bit set.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [NREQ_MAX-1:0] valid,
        input logic [IDX_W-1:0]    ptr,
        input int unsigned         nreq
    );
        logic [IDX_W-1:0] pick;
        logic             found;
        logic [IDX_W:0]   sum;
        logic [IDX_W:0]   idx;
        pick  = 3'd0;
        found = 1'b0;
        for (int k = 0; k < NREQ_MAX; k++) begin
            sum = {1'b0, ptr} + 4'(k);
            idx = (sum >= 4'(nreq)) ? (sum - 4'(nreq)) : sum;
            pick  = (!found && (32'(k) < nreq) && valid[idx[IDX_W-1:0]])
                    ? idx[IDX_W-1:0] : pick;
            found = found | ((32'(k) < nreq) && valid[idx[IDX_W-1:0]]);
        end
        return pick;
    endfunction

endpackage

// File: rtl/mult_pipe.sv
// Tagged pipelined 8x8 unsigned multiplier.
// Stage 0 registers {valid, id, a, b}; the product is formed from stage 0
// and carried through the remaining LAT-1 stages alongside valid and id.
// The whole pipeline freezes when en is low.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-low reset, clears every stage
//   en        advance enable
//   in_valid  op entering stage 0 (0 = bubble)
//   in_id     requester tag of the entering op
//   in_a/in_b operands
//   out_valid valid bit of the last stage
//   out_id    tag of the last stage
//   out_p     16-bit product of the last stage
module mult_pipe
    import mult_share_pkg::*;
#(
    parameter int LAT = 3,
    parameter int IDW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              in_valid,
    input  logic [IDW-1:0]    in_id,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    output logic              out_valid,
    output logic [IDW-1:0]    out_id,
    output logic [PROD_W-1:0] out_p
);

    logic [LAT-1:0]    vld_q;
    logic [IDW-1:0]    id_q [LAT];
    logic [OP_W-1:0]   a0_q;
    logic [OP_W-1:0]   b0_q;
    logic [PROD_W-1:0] prod_s;

    // Full-width product of the stage-0 operands; zero-extended so nothing truncates.
    assign prod_s = {8'd0, a0_q} * {8'd0, b0_q};

    // Stage-0 capture and valid/tag shift chain.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q <= '0;
            a0_q  <= 8'd0;
            b0_q  <= 8'd0;
            for (int k = 0; k < LAT; k++) begin
                id_q[k] <= '0;
            end
        end else if (en) begin
            vld_q[0] <= in_valid;
            id_q[0]  <= in_id;
            a0_q     <= in_a;
            b0_q     <= in_b;
            for (int k = 1; k < LAT; k++) begin
                vld_q[k] <= vld_q[k-1];
                id_q[k]  <= id_q[k-1];
            end
        end
    end

    generate
        if (LAT == 1) begin : g_lat1
            assign out_p = prod_s;
        end else begin : g_latn
            logic [PROD_W-1:0] p_q [1:LAT-1];

            // Product shift chain for the stages after stage 0.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int k = 1; k < LAT; k++) begin
                        p_q[k] <= 16'd0;
                    end
                end else if (en) begin
                    p_q[1] <= prod_s;
                    for (int k = 2; k < LAT; k++) begin
                        p_q[k] <= p_q[k-1];
                    end
                end
            end

            assign out_p = p_q[LAT-1];
        end
    endgenerate

    assign out_valid = vld_q[LAT-1];
    assign out_id    = id_q[LAT-1];

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one pipelined multiplier among NREQ requesters.
// Round-robin grant (one issue per cycle), requester tag carried with the
// operands so each product is returned with the ID of its owner.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   en                global advance; 0 freezes arbiter and pipeline
//   req_valid         per-requester operand valid
//   req_a/req_b       packed operands, requester i at [8i+7:8i]
//   req_ready         one-hot grant (combinational)
//   rsp_valid         product valid, one cycle per op, gated by en
//   rsp_id/rsp_data   owner and product; hold last value when rsp_valid=0
//   inflight          count of valid pipeline stages
//   issue_cnt         accepted-op counter, wraps
module mult_share_arbiter
    import mult_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int LAT  = 3,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [OP_W*NREQ-1:0] req_a,
    input  logic [OP_W*NREQ-1:0] req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [PROD_W-1:0]    rsp_data,
    output logic [3:0]           inflight,
    output logic [15:0]          issue_cnt
);

    logic [IDW-1:0]    ptr_q;
    logic [IDW-1:0]    ptr_d;
    logic [IDX_W-1:0]  pick_s;
    logic [IDW-1:0]    gnt_idx_s;
    logic              xfer_s;
    logic [OP_W-1:0]   a_s;
    logic [OP_W-1:0]   b_s;
    logic              pv_s;
    logic [IDW-1:0]    pid_s;
    logic [PROD_W-1:0] pp_s;
    logic [3:0]        inflight_q;
    logic [3:0]        inflight_d;
    logic [15:0]       issue_cnt_q;
    logic [15:0]       issue_cnt_d;
    logic [IDW-1:0]    rsp_id_q;
    logic [PROD_W-1:0] rsp_data_q;

    // Arbitration, operand mux, next-state and response muxing.
    always_comb begin
        pick_s    = rr_pick(NREQ_MAX'(req_valid), IDX_W'(ptr_q), NREQ);
        gnt_idx_s = IDW'(pick_s);
        // Any asserted valid while enabled guarantees the picked one transfers.
        xfer_s    = en & (|req_valid);
        req_ready = xfer_s ? (NREQ'(1'b1) << gnt_idx_s) : '0;
        a_s       = req_a[OP_W*gnt_idx_s +: OP_W];
        b_s       = req_b[OP_W*gnt_idx_s +: OP_W];

        if (!xfer_s) begin
            ptr_d = ptr_q;
        end else if (gnt_idx_s == IDW'(NREQ-1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = gnt_idx_s + IDW'(1);
        end

        issue_cnt_d = xfer_s ? (issue_cnt_q + 16'd1) : issue_cnt_q;
        // Each advance inserts one stage valid and retires the last one.
        inflight_d  = en ? (inflight_q + 4'(xfer_s) - 4'(pv_s)) : inflight_q;

        // A frozen pipeline must not present its last stage as a new response.
        rsp_valid = pv_s & en;
        rsp_id    = rsp_valid ? pid_s : rsp_id_q;
        rsp_data  = rsp_valid ? pp_s  : rsp_data_q;
    end

    // Pointer, counters and response hold registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q       <= '0;
            inflight_q  <= 4'd0;
            issue_cnt_q <= 16'd0;
            rsp_id_q    <= '0;
            rsp_data_q  <= 16'd0;
        end else begin
            ptr_q       <= ptr_d;
            inflight_q  <= inflight_d;
            issue_cnt_q <= issue_cnt_d;
            rsp_id_q    <= rsp_id;
            rsp_data_q  <= rsp_data;
        end
    end

    mult_pipe #(
        .LAT (LAT),
        .IDW (IDW)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (xfer_s),
        .in_id     (gnt_idx_s),
        .in_a      (a_s),
        .in_b      (b_s),
        .out_valid (pv_s),
        .out_id    (pid_s),
        .out_p     (pp_s)
    );

    assign inflight  = inflight_q;
    assign issue_cnt = issue_cnt_q;

endmodule
